// File: rtl/peripheral_bridge_if.sv
// Core-side and peripheral-side bus bundle for peripheral_bridge.
// The bridge is a slave to the core (slave modport) and a master to the peripherals (master modport).
interface peripheral_bridge_if;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         response;
  logic         error;

  logic [3:0]   slave_read;
  logic [3:0]   slave_write;
  logic [31:0]  slave_address;
  logic [31:0]  slave_write_data;
  logic [127:0] slave_read_data;
  logic [3:0]   slave_response;

  modport slave (
    input  read, write, address, write_data,
    output read_data, response, error
  );

  modport master (
    output slave_read, slave_write, slave_address, slave_write_data,
    input  slave_read_data, slave_response
  );
endinterface

// File: rtl/peripheral_bridge.sv
// Single-outstanding core-to-peripheral bridge: decodes the request into one of four windows.
// Optional ACCESS timeout enabled by defining BUS_TIMEOUT_EN.
module peripheral_bridge #(
  parameter logic [127:0] START_ADDRESSES = {32'h00004000, 32'h00003000, 32'h00002000, 32'h00001000},
  parameter logic [127:0] FINAL_ADDRESSES = {32'h00004002, 32'h00003002, 32'h00002002, 32'h00001002},
  parameter int unsigned  TIMEOUT_CYCLES  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  peripheral_bridge_if.slave  core_if,
  peripheral_bridge_if.master per_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESP    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // A zero-cycle timeout cannot be honoured: the strobe is always up for at least one cycle.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("peripheral_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        op_wr_q, op_wr_d;
  logic [1:0]  idx_q,   idx_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;

  logic        hit;
  logic [1:0]  hit_idx;
  logic        sel_resp;
  logic [31:0] sel_rdata;
  logic [3:0]  sel_vec;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Descending scan so the lowest matching window index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((core_if.address >= START_ADDRESSES[32*i +: 32]) &&
          (core_if.address <= FINAL_ADDRESSES[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  assign sel_resp  = per_if.slave_response[idx_q];
  assign sel_rdata = per_if.slave_read_data[32*idx_q +: 32];
  assign sel_vec   = 4'b0001 << idx_q;

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (core_if.read || core_if.write) begin
          // A simultaneous read and write is carried out as a write.
          op_wr_d = core_if.write;
          idx_d   = hit_idx;
          addr_d  = core_if.address;
          wdata_d = core_if.write_data;
          rdata_d = 32'h0;
          err_d   = ~hit;
          state_d = hit ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
`ifdef BUS_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (sel_resp) begin
          rdata_d = op_wr_q ? 32'h0 : sel_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'hDEADBEEF;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the core to drop its strobes so a held request is never replayed.
        if (!core_if.read && !core_if.write) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      idx_q   <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Outputs decode straight from reset-cleared registers, so reset silences them without a clock.
  assign per_if.slave_read       = ((state_q == S_ACCESS) && !op_wr_q) ? sel_vec : 4'b0000;
  assign per_if.slave_write      = ((state_q == S_ACCESS) &&  op_wr_q) ? sel_vec : 4'b0000;
  assign per_if.slave_address    = addr_q;
  assign per_if.slave_write_data = wdata_q;

  assign core_if.response  = (state_q == S_RESP);
  assign core_if.error     = (state_q == S_RESP) && err_q;
  assign core_if.read_data = (state_q == S_RESP) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_peripheral_bridge.sv
// Randomized scoreboard bench for peripheral_bridge with a window-decode reference model.
`timescale 1ns/1ps
module tb_peripheral_bridge;

  localparam int unsigned TO = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  peripheral_bridge_if bus();

  peripheral_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .core_if(bus),
    .per_if (bus)
  );

  logic [31:0] win_lo [4] = '{32'h00001000, 32'h00002000, 32'h00003000, 32'h00004000};
  logic [31:0] win_hi [4] = '{32'h00001002, 32'h00002002, 32'h00003002, 32'h00004002};

  typedef struct {
    logic        err;
    logic [31:0] data;
    int unsigned cyc;
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  int          bursts = 0;
  bit          prev_str = 1'b0;

  // Slave models: each selected slave answers after sl_wait strobe cycles; idle bits carry noise.
  logic [31:0] sl_data [4];
  logic [3:0]  noise   = 4'h0;
  int unsigned sl_wait = 0;
  int unsigned wcnt    = 0;
  logic [3:0]  strobes;
  logic [3:0]  resp;

  assign strobes = bus.slave_read | bus.slave_write;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    wcnt <= (strobes != 4'b0) ? wcnt + 1 : 0;
  end

  always_comb begin
    resp = 4'b0;
    for (int i = 0; i < 4; i++) begin
      resp[i] = strobes[i] ? (wcnt >= sl_wait) : noise[i];
    end
  end

  assign bus.slave_response  = resp;
  assign bus.slave_read_data = {sl_data[3], sl_data[2], sl_data[1], sl_data[0]};

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if (a >= win_lo[i] && a <= win_hi[i]) return i;
    end
    return -1;
  endfunction

  // Monitor: strobe and response checks against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      bursts   = 0;
      prev_str = 1'b0;
    end else begin
      if (strobes != 4'b0) begin
        if (!prev_str) bursts++;
        checks++;
        if (q.size() == 0 || q[0].idx < 0) begin
          errors++;
          $display("FAIL strobe_unexpected rd=%b wr=%b with no decoded request pending",
                   bus.slave_read, bus.slave_write);
        end else begin
          logic [3:0] v;
          v = 4'b0001 << q[0].idx;
          if (bus.slave_read !== (q[0].wr ? 4'b0 : v) || bus.slave_write !== (q[0].wr ? v : 4'b0) ||
              bus.slave_address !== q[0].addr || bus.slave_write_data !== q[0].wd) begin
            errors++;
            $display("FAIL strobe rd=%b wr=%b addr=%h wd=%h expected rd=%b wr=%b addr=%h wd=%h",
                     bus.slave_read, bus.slave_write, bus.slave_address, bus.slave_write_data,
                     q[0].wr ? 4'b0 : v, q[0].wr ? v : 4'b0, q[0].addr, q[0].wd);
          end
        end
      end
      prev_str = (strobes != 4'b0);

      if (bus.response) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL response_unexpected err=%b data=%h with empty scoreboard",
                   bus.error, bus.read_data);
        end else begin
          exp_t e;
          int   eb;
          e  = q.pop_front();
          eb = (e.idx >= 0) ? 1 : 0;
          if (bus.error !== e.err || bus.read_data !== e.data) begin
            errors++;
            $display("FAIL resp_value err=%b data=%h expected err=%b data=%h",
                     bus.error, bus.read_data, e.err, e.data);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL resp_latency cycle=%0d expected=%0d", cyc, e.cyc);
          end
          checks++;
          if (bursts != eb) begin
            errors++;
            $display("FAIL strobe_bursts got=%0d expected=%0d", bursts, eb);
          end
          bursts = 0;
        end
      end else begin
        checks++;
        if (bus.error !== 1'b0 || bus.read_data !== 32'h0) begin
          errors++;
          $display("FAIL idle_outputs err=%b data=%h expected err=0 data=0", bus.error, bus.read_data);
        end
      end
    end
  end

  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rdval, input int unsigned wt, input int unsigned hold);
    exp_t        e;
    int unsigned lat;
    bit          got;
    for (int i = 0; i < 4; i++) sl_data[i] = $urandom;
    noise   = 4'($urandom);
    sl_wait = wt;
    e.idx   = decode(addr);
    if (e.idx >= 0) sl_data[e.idx] = rdval;
    e.wr   = wr;
    e.addr = addr;
    e.wd   = wd;
    if (e.idx < 0) begin
      e.err = 1'b1; e.data = 32'h0; lat = 1;
    end else if (TIMEOUT_ON && wt >= TO) begin
      e.err = 1'b1; e.data = 32'hDEADBEEF; lat = 1 + TO;
    end else begin
      e.err = 1'b0; e.data = wr ? 32'h0 : rdval; lat = 2 + wt;
    end
    e.cyc = cyc + lat;
    q.push_back(e);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = addr;
    bus.write_data = wd;
    got = 1'b0;
    for (int k = 0; k < int'(lat) + 40 && !got; k++) begin
      @(posedge clk); #1;
      if (bus.response) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL no_response addr=%h response=0 expected a response within %0d cycles", addr, lat);
      q.delete();
    end
    repeat (hold) begin @(posedge clk); #1; end
    bus.read  = 1'b0;
    bus.write = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          w;
    int          s;
    int unsigned wt;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = 32'h0; bus.write_data = 32'h0;
    for (int i = 0; i < 4; i++) sl_data[i] = 32'h0;
    #1 rst_n = 1'b0;
    #12;
    chk("reset_response", 32'(bus.response), 32'h0);
    chk("reset_error", 32'(bus.error), 32'h0);
    chk("reset_read_data", bus.read_data, 32'h0);
    chk("reset_strobes", {24'h0, bus.slave_read, bus.slave_write}, 32'h0);
    chk("reset_slave_address", bus.slave_address, 32'h0);
    chk("reset_slave_wdata", bus.slave_write_data, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    txn(1'b0, 1'b1, 32'h00001000, 32'h000000A5, 32'h0, 0, 0);
    txn(1'b1, 1'b0, 32'h00002000, 32'h0, 32'h12345678, 3, 0);
    txn(1'b1, 1'b0, 32'h00008000, 32'h0, 32'h0, 0, 0);
    txn(1'b1, 1'b0, 32'h00003002, 32'h0, 32'hCAFEF00D, 1, 10);
    txn(1'b1, 1'b1, 32'h00004000, 32'h5A5A5A5A, 32'h11111111, 2, 1);
    txn(1'b1, 1'b0, 32'h00004003, 32'h0, 32'h0, 0, 0);
    txn(1'b0, 1'b1, 32'h00000FFF, 32'h1, 32'h0, 0, 0);
    if (TIMEOUT_ON) txn(1'b1, 1'b0, 32'h00003000, 32'h0, 32'h0, 1000, 0);

    for (int n = 0; n < 60; n++) begin
      w = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0, 1, 2: a = win_lo[w] + $urandom_range(0, 2);
        3:       a = win_hi[w] + 1;
        4:       a = win_lo[w] - 1;
        default: a = $urandom;
      endcase
      s  = $urandom_range(0, 2);
      wt = TIMEOUT_ON ? $urandom_range(0, TO - 1) : $urandom_range(0, 5);
      if (TIMEOUT_ON && $urandom_range(0, 7) == 0) wt = 1000;
      txn(s != 1, s != 0, a, $urandom, $urandom, wt, $urandom_range(0, 3));
    end

    // Reset in the middle of an access: strobes must vanish before any clock edge.
    for (int i = 0; i < 4; i++) sl_data[i] = $urandom;
    sl_wait = 1000;
    noise   = 4'h0;
    q.push_back('{err: 1'b0, data: 32'h0, cyc: 0, idx: 2, wr: 1'b0, addr: 32'h00003001, wd: 32'h0});
    bus.read = 1'b1; bus.write = 1'b0; bus.address = 32'h00003001; bus.write_data = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("access_strobe", {28'h0, bus.slave_read}, 32'h4);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {24'h0, bus.slave_read, bus.slave_write}, 32'h0);
    chk("rst_mid_response", 32'(bus.response), 32'h0);
    chk("rst_mid_read_data", bus.read_data, 32'h0);
    q.delete();
    bus.read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 32'h00003001, 32'h0, 32'h0BADF00D, 1, 0);
    txn(1'b0, 1'b1, 32'h00001002, 32'hFEEDFACE, 32'h0, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    chk("no_stray_strobes", 32'(bursts), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
